// File: rtl/lsu_mc_if.sv
// lsu_mc_if: upstream request/result and memory-port signals of the load/store unit.
//   slave  modport: the unit side (takes requests and memory responses, drives results and memory requests).
//   master modport: the environment side (issues requests, models memory).
//   Upstream: valid_i, ready_o, we_i, size_i, unsigned_i, addr_i, wdata_i, done_o, rdata_o, err_o.
//   Memory:   mem_req_o, mem_gnt_i, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_rvalid_i, mem_rdata_i.
interface lsu_mc_if #(
   parameter int XLEN = 32
);
   logic              valid_i;
   logic              ready_o;
   logic              we_i;
   logic [1:0]        size_i;
   logic              unsigned_i;
   logic [XLEN-1:0]   addr_i;
   logic [XLEN-1:0]   wdata_i;
   logic              done_o;
   logic [XLEN-1:0]   rdata_o;
   logic              err_o;
   logic              mem_req_o;
   logic              mem_gnt_i;
   logic              mem_we_o;
   logic [XLEN-1:0]   mem_addr_o;
   logic [XLEN-1:0]   mem_wdata_o;
   logic [XLEN/8-1:0] mem_wstrb_o;
   logic              mem_rvalid_i;
   logic [XLEN-1:0]   mem_rdata_i;
   modport slave (
      input  valid_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output ready_o, done_o, rdata_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
   );
   modport master (
      output valid_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  ready_o, done_o, rdata_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
   );
endinterface

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit with one outstanding request/grant/response memory access.
//   clk_i  : clock, rising edge.
//   rst_ni : asynchronous active-low reset.
//   bus    : lsu_mc_if.slave carrying the upstream request/result and the memory port.
//   XLEN   : 32 or 64; OFFW is derived (byte offset bits within a memory word).
module lsu_mc #(
   parameter int XLEN = 32,
   parameter int OFFW = $clog2(XLEN/8)
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   lsu_mc_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
   state_e            state_q, state_d;
   logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
   logic [1:0]        size_q, size_d;
   logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]        amask;
   logic              bad;
   logic [OFFW-1:0]   off;
   logic [OFFW+2:0]   bit_off;
   logic [XLEN-1:0]   sh, ext;
   logic [XLEN/8-1:0] smask;
   logic              req, st, done;
   // Alignment mask is (bytes-1): the low address bits that must be zero for the size.
   assign amask   = (4'd1 << bus.size_i) - 4'd1;
   assign bad     = (|(bus.addr_i[2:0] & amask[2:0])) | (XLEN == 32 && bus.size_i == 2'd3);
   assign off     = addr_q[OFFW-1:0];
   assign bit_off = {off, 3'b000};
   assign sh      = rdata_q >> bit_off;
   // Signed casts sign-extend; word loads on XLEN=32 are full width so unsigned_i has no effect.
   assign ext = size_q == 2'd0 ? (uns_q ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0])))  :
                size_q == 2'd1 ? (uns_q ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
                size_q == 2'd2 ? (uns_q ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;
   // Shifting all-ones left by the byte count leaves ~mask; a full-width shift yields all lanes.
   assign smask = ~({(XLEN/8){1'b1}} << (4'd1 << size_q));
   assign req   = state_q == REQ;
   assign st    = req & we_q;
   assign done  = state_q == DONE;
   assign bus.ready_o     = state_q == IDLE;
   assign bus.done_o      = done;
   assign bus.err_o       = done & err_q;
   assign bus.rdata_o     = (done && !err_q && !we_q) ? ext : '0;
   assign bus.mem_req_o   = req;
   assign bus.mem_we_o    = st;
   assign bus.mem_addr_o  = req ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
   assign bus.mem_wdata_o = st ? wdata_q << bit_off : '0;
   assign bus.mem_wstrb_o = st ? smask << off : '0;
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      uns_d   = uns_q;
      err_d   = err_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (bus.valid_i) begin
            we_d    = bus.we_i;
            uns_d   = bus.unsigned_i;
            size_d  = bus.size_i;
            addr_d  = bus.addr_i;
            wdata_d = bus.wdata_i;
            rdata_d = '0;
            err_d   = bad;
            state_d = bad ? DONE : REQ;
         end
         REQ:  state_d = bus.mem_gnt_i ? WAIT : REQ;
         WAIT: if (bus.mem_rvalid_i) begin
            rdata_d = bus.mem_rdata_i;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: directed self-checking bench for lsu_mc at XLEN=32 and XLEN=64.
//   Drives one instance of each width through its lsu_mc_if and checks results against hand-computed values.
module tb_lsu_mc;
   logic clk, rst_n;
   int   checks = 0, failures = 0;
   lsu_mc_if #(.XLEN(32)) b32();
   lsu_mc_if #(.XLEN(64)) b64();
   lsu_mc #(.XLEN(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(b32));
   lsu_mc #(.XLEN(64)) dut64 (.clk_i(clk), .rst_ni(rst_n), .bus(b64));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      logic        ready, done, err, req, we;
      logic [63:0] rdata, addr, wdata;
      logic [7:0]  wstrb;
   } obs_t;
   obs_t o;
   function automatic obs_t get(bit w64);
      obs_t r;
      if (w64) begin
         r.ready = b64.ready_o; r.done = b64.done_o; r.err = b64.err_o;
         r.req = b64.mem_req_o; r.we = b64.mem_we_o; r.rdata = b64.rdata_o;
         r.addr = b64.mem_addr_o; r.wdata = b64.mem_wdata_o; r.wstrb = b64.mem_wstrb_o;
      end else begin
         r.ready = b32.ready_o; r.done = b32.done_o; r.err = b32.err_o;
         r.req = b32.mem_req_o; r.we = b32.mem_we_o; r.rdata = 64'(b32.rdata_o);
         r.addr = 64'(b32.mem_addr_o); r.wdata = 64'(b32.mem_wdata_o); r.wstrb = 8'(b32.mem_wstrb_o);
      end
      return r;
   endfunction
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive_req(bit w64, bit v, bit we, logic [1:0] sz, bit uns, logic [63:0] a, logic [63:0] wd);
      if (w64) begin
         b64.valid_i = v; b64.we_i = we; b64.size_i = sz; b64.unsigned_i = uns; b64.addr_i = a; b64.wdata_i = wd;
      end else begin
         b32.valid_i = v; b32.we_i = we; b32.size_i = sz; b32.unsigned_i = uns; b32.addr_i = a[31:0]; b32.wdata_i = wd[31:0];
      end
   endtask
   task automatic drive_mem(bit w64, bit g, bit rv, logic [63:0] d);
      if (w64) begin
         b64.mem_gnt_i = g; b64.mem_rvalid_i = rv; b64.mem_rdata_i = d;
      end else begin
         b32.mem_gnt_i = g; b32.mem_rvalid_i = rv; b32.mem_rdata_i = d[31:0];
      end
   endtask
   task automatic check_reset_outputs(string tag, bit w64);
      o = get(w64);
      check({tag, ".ready"}, 64'(o.ready), 64'd1);
      check({tag, ".done"},  64'(o.done),  64'd0);
      check({tag, ".err"},   64'(o.err),   64'd0);
      check({tag, ".rdata"}, o.rdata,      64'd0);
      check({tag, ".req"},   64'(o.req),   64'd0);
      check({tag, ".we"},    64'(o.we),    64'd0);
      check({tag, ".addr"},  o.addr,       64'd0);
      check({tag, ".wdata"}, o.wdata,      64'd0);
      check({tag, ".wstrb"}, 64'(o.wstrb), 64'd0);
   endtask
   // Best-case access: grant in the first REQ cycle, rvalid in the first WAIT cycle.
   task automatic xact(string tag, bit w64, bit we, logic [1:0] sz, bit uns, logic [63:0] a, logic [63:0] wd,
                       logic [63:0] mw, logic [63:0] e_addr, logic [63:0] e_wdata, logic [7:0] e_wstrb,
                       logic [63:0] e_rdata);
      drive_req(w64, 1'b1, we, sz, uns, a, wd);
      step();
      drive_req(w64, 1'b0, we, sz, uns, a, wd);
      o = get(w64);
      check({tag, ".req"},   64'(o.req),   64'd1);
      check({tag, ".ready"}, 64'(o.ready), 64'd0);
      check({tag, ".we"},    64'(o.we),    64'(we));
      check({tag, ".addr"},  o.addr,       e_addr);
      check({tag, ".wdata"}, o.wdata,      e_wdata);
      check({tag, ".wstrb"}, 64'(o.wstrb), 64'(e_wstrb));
      drive_mem(w64, 1'b1, 1'b0, 64'd0);
      step();
      drive_mem(w64, 1'b0, 1'b1, mw);
      o = get(w64);
      check({tag, ".wait_req"},  64'(o.req),  64'd0);
      check({tag, ".wait_done"}, 64'(o.done), 64'd0);
      step();
      drive_mem(w64, 1'b0, 1'b0, 64'd0);
      o = get(w64);
      check({tag, ".done"},  64'(o.done), 64'd1);
      check({tag, ".err"},   64'(o.err),  64'd0);
      check({tag, ".rdata"}, o.rdata,     e_rdata);
      step();
      o = get(w64);
      check({tag, ".done_end"}, 64'(o.done),  64'd0);
      check({tag, ".ready_end"}, 64'(o.ready), 64'd1);
   endtask
   // Misaligned/unsupported access: done with err one cycle after accept, no memory request.
   task automatic err_xact(string tag, bit w64, bit we, logic [1:0] sz, logic [63:0] a);
      drive_req(w64, 1'b1, we, sz, 1'b0, a, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      drive_req(w64, 1'b0, we, sz, 1'b0, a, 64'd0);
      o = get(w64);
      check({tag, ".done"},  64'(o.done),  64'd1);
      check({tag, ".err"},   64'(o.err),   64'd1);
      check({tag, ".rdata"}, o.rdata,      64'd0);
      check({tag, ".req"},   64'(o.req),   64'd0);
      check({tag, ".ready"}, 64'(o.ready), 64'd0);
      step();
      o = get(w64);
      check({tag, ".done_end"}, 64'(o.done),  64'd0);
      check({tag, ".err_end"},  64'(o.err),   64'd0);
      check({tag, ".req_end"},  64'(o.req),   64'd0);
      check({tag, ".ready_end"}, 64'(o.ready), 64'd1);
   endtask
   initial begin
      rst_n = 1'b0;
      drive_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
      drive_req(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
      drive_mem(1'b0, 1'b0, 1'b0, 64'd0);
      drive_mem(1'b1, 1'b0, 1'b0, 64'd0);
      step();
      step();
      check_reset_outputs("rst32", 1'b0);
      check_reset_outputs("rst64", 1'b1);
      rst_n = 1'b1;
      step();
      // XLEN=32 loads and store
      xact("lb",  1'b0, 1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 64'h8012_3456, 64'h1000, 64'd0, 8'h0, 64'hFFFF_FF80);
      xact("lbu", 1'b0, 1'b0, 2'd0, 1'b1, 64'h1003, 64'd0, 64'h8012_3456, 64'h1000, 64'd0, 8'h0, 64'h0000_0080);
      xact("sh",  1'b0, 1'b1, 2'd1, 1'b0, 64'h1002, 64'h0000_ABCD, 64'h1234_5678, 64'h1000, 64'hABCD_0000, 8'hC, 64'd0);
      xact("lh",  1'b0, 1'b0, 2'd1, 1'b0, 64'h1002, 64'd0, 64'h8001_7FFF, 64'h1000, 64'd0, 8'h0, 64'hFFFF_8001);
      xact("lw_u", 1'b0, 1'b0, 2'd2, 1'b1, 64'h1004, 64'd0, 64'h8765_4321, 64'h1004, 64'd0, 8'h0, 64'h8765_4321);
      xact("sb",  1'b0, 1'b1, 2'd0, 1'b0, 64'h1001, 64'h0000_00A5, 64'd0, 64'h1000, 64'h0000_A500, 8'h2, 64'd0);
      // XLEN=32 error cases
      err_xact("lw_mis", 1'b0, 1'b0, 2'd2, 64'h1002);
      err_xact("d32",    1'b0, 1'b0, 2'd3, 64'h1000);
      err_xact("sh_mis", 1'b0, 1'b1, 2'd1, 64'h1001);
      // Grant held off three cycles, rvalid two cycles after the grant cycle
      drive_req(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h1004, 64'd0);
      step();
      drive_req(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 64'h1004, 64'd0);
      for (int i = 0; i < 4; i++) begin
         o = get(1'b0);
         check($sformatf("slow.req%0d", i),   64'(o.req),   64'd1);
         check($sformatf("slow.addr%0d", i),  o.addr,       64'h1004);
         check($sformatf("slow.ready%0d", i), 64'(o.ready), 64'd0);
         drive_mem(1'b0, i == 3, 1'b0, 64'd0);
         step();
      end
      drive_mem(1'b0, 1'b0, 1'b0, 64'd0);
      o = get(1'b0);
      check("slow.req_drop", 64'(o.req),   64'd0);
      check("slow.ready5",   64'(o.ready), 64'd0);
      check("slow.done5",    64'(o.done),  64'd0);
      step();
      drive_mem(1'b0, 1'b0, 1'b1, 64'h1122_3344);
      o = get(1'b0);
      check("slow.ready6", 64'(o.ready), 64'd0);
      check("slow.done6",  64'(o.done),  64'd0);
      step();
      drive_mem(1'b0, 1'b0, 1'b0, 64'd0);
      o = get(1'b0);
      check("slow.done7",  64'(o.done),  64'd1);
      check("slow.ready7", 64'(o.ready), 64'd0);
      check("slow.rdata",  o.rdata,      64'h1122_3344);
      step();
      // Reset pulse while waiting for the response, then a late rvalid
      drive_req(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h1008, 64'd0);
      step();
      drive_req(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 64'h1008, 64'd0);
      drive_mem(1'b0, 1'b1, 1'b0, 64'd0);
      step();
      drive_mem(1'b0, 1'b0, 1'b0, 64'd0);
      o = get(1'b0);
      check("rstw.in_wait_ready", 64'(o.ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rstw.async", 1'b0);
      step();
      rst_n = 1'b1;
      drive_mem(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF);
      step();
      drive_mem(1'b0, 1'b0, 1'b0, 64'd0);
      o = get(1'b0);
      check("rstw.late_done",  64'(o.done),  64'd0);
      check("rstw.late_ready", 64'(o.ready), 64'd1);
      check("rstw.late_req",   64'(o.req),   64'd0);
      step();
      o = get(1'b0);
      check("rstw.idle_done", 64'(o.done), 64'd0);
      xact("rstw.next", 1'b0, 1'b0, 2'd1, 1'b0, 64'h100A, 64'd0, 64'h8001_0000, 64'h1008, 64'd0, 8'h0, 64'hFFFF_8001);
      // XLEN=64
      xact("ld",  1'b1, 1'b0, 2'd3, 1'b0, 64'h2008, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'h2008, 64'd0, 8'h00,
           64'hDEAD_BEEF_CAFE_F00D);
      xact("lwu", 1'b1, 1'b0, 2'd2, 1'b1, 64'h200C, 64'd0, 64'h8000_0000_0000_0000, 64'h2008, 64'd0, 8'h00,
           64'h0000_0000_8000_0000);
      xact("lw64", 1'b1, 1'b0, 2'd2, 1'b0, 64'h200C, 64'd0, 64'h8000_0000_0000_0000, 64'h2008, 64'd0, 8'h00,
           64'hFFFF_FFFF_8000_0000);
      xact("sd",  1'b1, 1'b1, 2'd3, 1'b0, 64'h2010, 64'h0123_4567_89AB_CDEF, 64'd0, 64'h2010,
           64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0);
      xact("sh64", 1'b1, 1'b1, 2'd1, 1'b0, 64'h2016, 64'h0000_0000_0000_BEEF, 64'd0, 64'h2010,
           64'hBEEF_0000_0000_0000, 8'hC0, 64'd0);
      err_xact("ld_mis", 1'b1, 1'b0, 2'd3, 64'h2004);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lsu_mc.md
# lsu_mc

Multi-cycle, parametrised load/store unit for the execute stage. It replaces the single-cycle, DPI-backed LSU with a registered request/grant/response memory port. It handles one outstanding access at a time, supports XLEN of 32 or 64 including doubleword and unsigned-word loads, and detects misaligned or unsupported accesses. Sub-word extraction, sign/zero extension, write-data lane placement and byte strobes are generated internally.

## Interface
Parameters:
- XLEN, 32, datapath and memory word width; legal values 32 and 64.
- OFFW, $clog2(XLEN/8), byte-offset bits within a memory word. Derived; do not override.

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream request valid.
- ready_o  out  1  unit can accept a request.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- unsigned_i  in  1  zero-extend the load result; ignored for stores.
- addr_i  in  XLEN  byte address.
- wdata_i  in  XLEN  store data, right-aligned.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  XLEN  extended load result; valid while done_o=1.
- err_o  out  1  misaligned or unsupported access; valid while done_o=1.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory accepted the request this cycle.
- mem_we_o  out  1  write request.
- mem_addr_o  out  XLEN  word-aligned address: addr with low OFFW bits cleared.
- mem_wdata_o  out  XLEN  lane-placed store data.
- mem_wstrb_o  out  XLEN/8  byte strobes; all zero for loads.
- mem_rvalid_i  in  1  response/ack for both loads and stores.
- mem_rdata_i  in  XLEN  full read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE: ready_o=1. On valid_i, latch we, size, unsigned, addr and wdata.
  - If the access is misaligned (size 1 with addr[0]≠0; size 2 with addr[1:0]≠0; size 3 with addr[2:0]≠0), go to DONE with err set.
  - If size 3 and XLEN=32, also go to DONE with err set.
  - Otherwise go to REQ.
- REQ: mem_req_o=1, with mem_* outputs driven from registers and held stable. On mem_gnt_i go to WAIT. mem_rvalid_i is ignored in REQ.
- WAIT: on mem_rvalid_i, capture mem_rdata_i into the result register, then go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. ready_o=0 in DONE, so no back-to-back accept in this cycle.
- Store lane placement: data shifted left by 8*addr[OFFW-1:0]. Strobe = ((1<<(1<<size))-1) << addr offset.
- Load extraction: word shifted right by 8*offset and truncated to the access size. Sign-extend unless unsigned_i. Word loads under XLEN=32 ignore unsigned_i.
- When err_o=1, rdata_o=0 and no memory transaction is issued.
- rdata_o is 0 for stores.

## Timing
- Reset values: ready_o=1, done_o=0, err_o=0, rdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wstrb_o=0.
- Asserting rst_ni low in any state forces IDLE within the same cycle, with all outputs at reset values. A pending memory response after reset is ignored.
- Best-case latency: accept at cycle T; REQ at T+1 with grant; WAIT at T+2 with rvalid; done_o at T+3.
- Error latency: done_o with err_o=1 at T+1.
- mem_req_o must never drop before mem_gnt_i. Address, data, strobe and we must be constant while requested.
- Throughput is one access per (latency+1) cycles; no pipelining.

## Test plan
- XLEN=32, LB at 0x1003, mem word 0x80123456 → mem_addr 0x1000, wstrb 0x0, rdata 0xFFFFFF80. Same access with LBU → 0x00000080.
- XLEN=32, SH at 0x1002, wdata 0x0000ABCD → mem_we=1, mem_wdata 0xABCD0000, wstrb 4'b1100. done_o one cycle after rvalid.
- XLEN=32, LW at 0x1002 → done_o with err_o=1 at T+1, rdata 0, mem_req_o never asserted. A size-3 request → err_o=1.
- Grant held off 3 cycles, rvalid 2 cycles later → mem_req_o high for 4 cycles with stable address, done_o at T+7, ready_o low throughout.
- Reset pulse during WAIT, followed by a late rvalid → all outputs at reset values, no done_o, next request handled normally.
- XLEN=64: LD at 0x2008 returns 0xDEADBEEF_CAFEF00D. LWU at 0x200C with word 0x80000000_00000000 → rdata 0x0000000080000000. SD at 0x2010 → wstrb 0xFF.
